// File: rtl/sub_compare_pipe.sv
// Two-stage 32-bit subtractor/comparator: diff, eq, signed and unsigned less-than.
// The borrow chain is cut at bit 16; the low half resolves in stage 1, the high half in stage 2.
module sub_compare_pipe (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] diff,
   output logic        eq,
   output logic        lt_s,
   output logic        lt_u
);

   logic        adv;
   logic        s1_valid;
   logic [15:0] s1_lo;
   logic        s1_bor;
   logic [15:0] s1_ahi;
   logic [15:0] s1_bhi;
   logic        s1_as;
   logic        s1_bs;
   logic [16:0] lo_sub;
   logic [16:0] hi;

   // Both stages share one stall: the pipe moves only when the output slot frees up.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign lo_sub = {1'b0, a[15:0]} - {1'b0, b[15:0]};
   assign hi     = {1'b0, s1_ahi} - {1'b0, s1_bhi} - {16'd0, s1_bor};

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_lo    <= 16'd0;
         s1_bor   <= 1'b0;
         s1_ahi   <= 16'd0;
         s1_bhi   <= 16'd0;
         s1_as    <= 1'b0;
         s1_bs    <= 1'b0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_lo    <= lo_sub[15:0];
         s1_bor   <= lo_sub[16];
         s1_ahi   <= a[31:16];
         s1_bhi   <= b[31:16];
         s1_as    <= a[31];
         s1_bs    <= b[31];
      end
   end

   // Differing signs decide signed order directly; otherwise the result sign does.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         diff      <= 32'd0;
         eq        <= 1'b0;
         lt_s      <= 1'b0;
         lt_u      <= 1'b0;
      end else if (adv) begin
         out_valid <= s1_valid;
         diff      <= {hi[15:0], s1_lo};
         eq        <= (hi[15:0] == 16'd0) && (s1_lo == 16'd0);
         lt_s      <= (s1_as != s1_bs) ? s1_as : hi[15];
         lt_u      <= hi[16];
      end
   end

endmodule

// File: tb/tb_sub_compare_pipe.sv
// Directed and random checks of sub_compare_pipe against a 33-bit reference subtract
// and a cycle-level occupancy model of the two-slot pipe.
module tb_sub_compare_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        eq;
   logic        lt_s;
   logic        lt_u;

   int total = 0;
   int bad   = 0;

   logic [34:0] q[$];
   logic        mod_ov  = 1'b0;
   logic        mod_s1v = 1'b0;
   logic        prev_stall = 1'b0;
   logic [34:0] prev_res = '0;

   sub_compare_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .eq        (eq),
      .lt_s      (lt_s),
      .lt_u      (lt_u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed result: {eq, lt_s, lt_u, diff}
   function automatic logic [34:0] ref_res(input logic [31:0] x, input logic [31:0] y);
      logic [32:0] d;
      d = {1'b0, x} - {1'b0, y};
      return {(x == y), ($signed(x) < $signed(y)), d[32], d[31:0]};
   endfunction

   function automatic logic [34:0] dut_res();
      return {eq, lt_s, lt_u, diff};
   endfunction

   task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: apply inputs, check the model at the falling edge, advance the model.
   task automatic drive(input logic rst, input logic v, input logic [31:0] aa,
                        input logic [31:0] bb, input logic ordy, output logic acc);
      logic adv_m;
      reset     = rst;
      in_valid  = v;
      a         = aa;
      b         = bb;
      out_ready = ordy;
      @(negedge clk);
      adv_m = !mod_ov || ordy;
      acc   = v && adv_m && !rst;
      chk("out_valid", 35'(out_valid), 35'(mod_ov));
      chk("in_ready", 35'(in_ready), 35'(adv_m));
      if (prev_stall) chk("stall_hold", dut_res(), prev_res);
      if (mod_ov) begin
         if (q.size() == 0) chk("sb_empty", 35'(q.size()), 35'd1);
         else chk("result", dut_res(), q[0]);
      end
      prev_stall = mod_ov && !ordy && !rst;
      prev_res   = dut_res();
      if (rst) begin
         mod_ov  = 1'b0;
         mod_s1v = 1'b0;
         q.delete();
      end else if (adv_m) begin
         if (mod_ov && q.size() != 0) void'(q.pop_front());
         mod_ov  = mod_s1v;
         mod_s1v = acc;
         if (acc) q.push_back(ref_res(aa, bb));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        acc;
      logic [5:0]  pat;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sent;
      int          cyc;

      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;

      // Reset and idle
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      chk("rst_out_valid", 35'(out_valid), 35'd0);
      chk("rst_in_ready", 35'(in_ready), 35'd1);
      chk("rst_outputs", dut_res(), 35'd0);

      // Accept attempted while reset is held: must not emerge
      drive(1'b1, 1'b1, 32'd5, 32'd3, 1'b1, acc);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      chk("rst_accept_1", 35'(out_valid), 35'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      chk("rst_accept_2", 35'(out_valid), 35'd0);

      // 5 - 3, one cycle of latency after the accept edge
      drive(1'b0, 1'b1, 32'd5, 32'd3, 1'b1, acc);
      chk("5m3_lat", 35'(out_valid), 35'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      chk("5m3_valid", 35'(out_valid), 35'd1);
      chk("5m3_res", dut_res(), {3'b000, 32'd2});

      // Boundary vectors back-to-back
      drive(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, acc);
      drive(1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, acc);
      chk("bnd0_valid", 35'(out_valid), 35'd1);
      chk("bnd0_res", dut_res(), {3'b011, 32'hFFFF_FFFF});
      drive(1'b0, 1'b1, 32'h0001_0000, 32'h0000_FFFF, 1'b1, acc);
      chk("bnd1_valid", 35'(out_valid), 35'd1);
      chk("bnd1_res", dut_res(), {3'b010, 32'h7FFF_FFFF});
      drive(1'b0, 1'b1, 32'h1234_ABCD, 32'h1234_ABCD, 1'b1, acc);
      chk("bnd2_valid", 35'(out_valid), 35'd1);
      chk("bnd2_res", dut_res(), {3'b000, 32'h0000_0001});
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      chk("bnd3_valid", 35'(out_valid), 35'd1);
      chk("bnd3_res", dut_res(), {3'b100, 32'h0000_0000});
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);

      // Backpressure: out_ready pattern 1,0,0,1,0,1 repeating
      pat  = 6'b101001;
      sent = 0;
      cyc  = 0;
      ra   = $urandom;
      rb   = $urandom;
      while ((sent < 6 || q.size() != 0) && cyc < 100) begin
         drive(1'b0, (sent < 6), ra, rb, pat[cyc % 6], acc);
         if (acc) begin
            sent++;
            ra = $urandom;
            rb = $urandom;
         end
         cyc++;
      end
      chk("bp_done", 35'(q.size()), 35'd0);

      // Reset at the edge where the first of two results would appear
      drive(1'b0, 1'b1, 32'h0000_1111, 32'h0000_0001, 1'b1, acc);
      drive(1'b1, 1'b1, 32'h0000_2222, 32'h0000_0002, 1'b1, acc);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
         chk("midrst_quiet", 35'(out_valid), 35'd0);
      end
      drive(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, acc);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
      chk("midrst_valid", 35'(out_valid), 35'd1);
      chk("midrst_res", dut_res(), {3'b011, 32'hFFFF_FFF0});
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);

      // Random regression with random handshakes and some equal operands
      for (int i = 0; i < 10000; i++) begin
         ra = $urandom;
         rb = ($urandom_range(99) < 5) ? ra : $urandom;
         drive(1'b0, 1'($urandom_range(1)), ra, rb, 1'($urandom_range(1)), acc);
      end
      cyc = 0;
      while (q.size() != 0 && cyc < 20) begin
         drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, acc);
         cyc++;
      end
      chk("rand_drain", 35'(q.size()), 35'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sub_compare_pipe.md
# sub_compare_pipe

Two-stage pipelined 32-bit subtractor/comparator with valid/ready handshakes on both sides. It computes `a - b` and derives the comparison flags needed by the RV32I datapath: equality, signed less-than and unsigned less-than (borrow). It is the subtract-side counterpart of the core's DSP adder and serves SUB, SLT/SLTU and branch-compare requests. To shorten the critical path, the borrow chain is split at bit 16 across the two stages.

## Interface
Parameters: none (width fixed at 32).

Ports:
- `clk` — input, 1 — single clock; all state changes on its rising edge.
- `reset` — input, 1 — synchronous, active-high reset.
- `in_valid` — input, 1 — an operand pair is presented.
- `in_ready` — output, 1 — the block accepts the pair this cycle.
- `a` — input, 32 — minuend.
- `b` — input, 32 — subtrahend.
- `out_valid` — output, 1 — a result is presented.
- `out_ready` — input, 1 — the consumer takes the result this cycle.
- `diff` — output, 32 — `(a - b) mod 2^32`.
- `eq` — output, 1 — asserted when `a == b`.
- `lt_s` — output, 1 — asserted when `a < b` as two's-complement values.
- `lt_u` — output, 1 — asserted when `a < b` as unsigned values (borrow out of bit 31).

## Operation
- Global stall signal: `adv = !out_valid || out_ready`. Both stages move together when `adv = 1`.
- `in_ready = adv` (combinational). An operand pair is accepted when `in_valid && in_ready`.
- Stage 1, on `adv`:
  - `s1_valid <= in_valid`.
  - `s1_lo <= a[15:0] - b[15:0]`, keeping 16 bits; `s1_bor <=` borrow out of bit 15.
  - `s1_ahi <= a[31:16]`; `s1_bhi <= b[31:16]`.
  - `s1_as <= a[31]`; `s1_bs <= b[31]`.
- Stage 2 (the output registers), on `adv`:
  - `out_valid <= s1_valid`.
  - `hi = s1_ahi - s1_bhi - s1_bor` (17-bit result). `diff <= {hi[15:0], s1_lo}`.
  - `lt_u <= hi[16]` (the borrow).
  - `eq <= (hi[15:0] == 0) && (s1_lo == 0)`.
  - `lt_s <= (s1_as != s1_bs) ? s1_as : hi[15]`.
- When `adv = 0`, every register holds its value; outputs stay stable while `out_valid && !out_ready`.
- Data registers may load garbage when their stage's valid bit is 0. Outputs are only meaningful while `out_valid = 1`.
- Bubbles are not collapsed. A cycle with `in_valid = 0` and `adv = 1` injects a bubble.
- Arithmetic is implemented in fabric; no DSP primitive is used.

## Timing
- Reset (synchronous, takes priority over `adv`):
  - `s1_valid = 0`, `out_valid = 0`.
  - `diff`, `eq`, `lt_s`, `lt_u` = 0; all stage-1 data registers = 0.
  - `in_ready` therefore reads 1 in the first cycle after reset.
- Latency: a pair accepted at edge N appears with `out_valid = 1` after edge N+1, provided no stall occurs. Each stall cycle adds one cycle of latency.
- Throughput: one result per cycle while `out_ready = 1`.
- Stall: with `out_valid = 1` and `out_ready = 0`, `in_ready = 0`. Nothing is accepted and nothing is lost. At most two results are in flight.
- Simultaneous accept and consume in the same cycle: the pipeline shifts, with no bubble and no duplication.
- Reset asserted mid-operation: all in-flight results are discarded; no `out_valid` pulse may appear for them after reset deasserts.
- `a` and `b` are only sampled on an accept edge; changes at other times have no effect.

## Test plan
- Reset, then idle: `out_valid = 0`, `in_ready = 1`, all outputs 0. Hold `reset` across an accept: nothing emerges.
- Send `a = 5`, `b = 3` at edge N, with `out_ready = 1` held: at N+1, `out_valid = 1`, `diff = 2`, `eq = 0`, `lt_s = 0`, `lt_u = 0`.
- Boundary vectors, one per cycle, back-to-back:
  - `0 - 1` gives `diff = 0xFFFFFFFF`, `lt_s = 1`, `lt_u = 1`.
  - `0x80000000 - 1` gives `0x7FFFFFFF`, `lt_s = 1`, `lt_u = 0`.
  - `0x00010000 - 0x0000FFFF` gives `0x00000001` (cross-half borrow), with all flags 0.
  - `0x1234ABCD - 0x1234ABCD` gives `diff = 0`, `eq = 1`.
  - All four results must appear on four consecutive cycles.
- Backpressure: stream 6 random pairs while `out_ready` toggles 1,0,0,1,0,1,… Results must come out in order and match a reference model. `diff` must stay stable while stalled, and `in_ready` must equal `!out_valid || out_ready` every cycle.
- Reset mid-operation: accept two pairs, assert `reset` for one cycle at the edge where the first result appears. Afterwards `out_valid` must stay 0 until a new pair is sent, and the new pair's result must be correct.
- Random regression: 10,000 random pairs with random `in_valid`/`out_ready` and 5% forced equal operands. Compare all four outputs against `a - b` computed at 33 bits and a signed compare.
